// File: rtl/mips_core_param.sv
// Parametrised single-issue MIPS-style execute block: R-type ALU ops, ADDI and a
// multi-cycle binary GCD against an internal register file, with a valid/ready front end.
module mips_core_param #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 6,
    parameter int unsigned NUM_OUT  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               instruction,
    input  logic [5*NUM_OUT-1:0]      out_sel,
    output logic                      out_valid,
    output logic                      instruction_fail,
    output logic [2:0]                fail_code,
    output logic [DATA_W*NUM_OUT-1:0] out_data
);

    localparam logic [5:0] OpR     = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [6:0] FnAdd   = 7'b0100000;
    localparam logic [6:0] FnSub   = 7'b0100010;
    localparam logic [6:0] FnAnd   = 7'b0100100;
    localparam logic [6:0] FnOr    = 7'b0100101;
    localparam logic [6:0] FnNor   = 7'b0100111;
    localparam logic [6:0] FnSltu  = 7'b0101010;
    localparam logic [6:0] FnSll   = 7'b0000000;
    localparam logic [6:0] FnSrl   = 7'b0000010;
    localparam logic [6:0] FnGcd   = 7'b1111000;
    localparam logic [5:0] NumRegs = 6'(NUM_REGS);

    typedef logic [DATA_W-1:0] word_t;
    typedef word_t reg_arr_t [NUM_REGS];
    typedef enum logic [1:0] {StIdle, StDecode, StGcd, StDone} state_e;

    state_e               state_q, state_d;
    reg_arr_t             regs_q, regs_d;
    logic [31:0]          instr_q, instr_d;
    logic [5*NUM_OUT-1:0] sel_q, sel_d;
    word_t                a_q, a_d, b_q, b_d;
    logic [5:0]           k_q, k_d;
    logic                 fail_q, fail_d;
    logic [2:0]           code_q, code_d;

    // Out-of-range addresses read as zero.
    function automatic word_t rd_reg(input reg_arr_t r, input logic [4:0] addr);
        word_t v;
        v = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (5'(i) == addr) v = r[i];
        end
        return v;
    endfunction

    function automatic reg_arr_t wr_reg(input reg_arr_t r, input logic [4:0] addr,
                                        input word_t v);
        reg_arr_t o;
        o = r;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (5'(i) == addr) o[i] = v;
        end
        return o;
    endfunction

    logic [5:0] opcode;
    logic [4:0] rs, rt, rd;
    logic [3:0] shamt;
    logic [6:0] func;
    word_t      rs_val, rt_val, imm_w, alu_res, gcd_res;
    logic       is_r, is_addi, func_ok, bad_reg, is_gcd, gcd_done;
    logic [2:0] dec_code;

    always_comb begin
        opcode  = instr_q[31:26];
        rs      = instr_q[25:21];
        rt      = instr_q[20:16];
        rd      = instr_q[15:11];
        shamt   = instr_q[10:7];
        func    = instr_q[6:0];
        imm_w   = word_t'(instr_q[15:0]);
        rs_val  = rd_reg(regs_q, rs);
        rt_val  = rd_reg(regs_q, rt);
        is_r    = (opcode == OpR);
        is_addi = (opcode == OpAddi);
        is_gcd  = is_r && (func == FnGcd);
        func_ok = (func == FnAdd) || (func == FnSub) || (func == FnAnd) || (func == FnOr) ||
                  (func == FnNor) || (func == FnSltu) || (func == FnSll) ||
                  (func == FnSrl) || (func == FnGcd);
        bad_reg = ({1'b0, rs} >= NumRegs) || ({1'b0, rt} >= NumRegs) ||
                  (is_r && ({1'b0, rd} >= NumRegs));
        if (!is_r && !is_addi)                             dec_code = 3'd1;
        else if (is_r && !func_ok)                         dec_code = 3'd2;
        else if (bad_reg)                                  dec_code = 3'd3;
        else if (is_gcd && (rs_val == '0 || rt_val == '0)) dec_code = 3'd4;
        else                                               dec_code = 3'd0;

        case (func)
            FnAdd:   alu_res = rs_val + rt_val;
            FnSub:   alu_res = rs_val - rt_val;
            FnAnd:   alu_res = rs_val & rt_val;
            FnOr:    alu_res = rs_val | rt_val;
            FnNor:   alu_res = ~(rs_val | rt_val);
            FnSltu:  alu_res = word_t'(rs_val < rt_val);
            FnSll:   alu_res = rt_val << shamt;
            FnSrl:   alu_res = rt_val >> shamt;
            default: alu_res = '0;
        endcase
        if (is_addi) alu_res = rs_val + imm_w;
    end

    // Stein termination: the common odd part is already known once any of these hold.
    always_comb begin
        gcd_done = (a_q == b_q) || (a_q == word_t'(1)) || (b_q == word_t'(1)) ||
                   (a_q == '0) || (b_q == '0);
        if (a_q == '0)                                   gcd_res = b_q;
        else if (b_q == '0)                              gcd_res = a_q;
        else if (a_q == word_t'(1) || b_q == word_t'(1)) gcd_res = word_t'(1);
        else                                             gcd_res = a_q;
    end

    always_comb begin
        state_d = state_q;
        regs_d  = regs_q;
        instr_d = instr_q;
        sel_d   = sel_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        fail_d  = fail_q;
        code_d  = code_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    instr_d = instruction;
                    sel_d   = out_sel;
                    fail_d  = 1'b0;
                    code_d  = 3'd0;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = StDone;
                if (dec_code != 3'd0) begin
                    fail_d = 1'b1;
                    code_d = dec_code;
                end else if (is_gcd) begin
                    a_d     = rs_val;
                    b_d     = rt_val;
                    k_d     = '0;
                    state_d = StGcd;
                end else begin
                    regs_d = wr_reg(regs_q, is_r ? rd : rt, alu_res);
                end
            end
            StGcd: begin
                if (gcd_done) begin
                    regs_d  = wr_reg(regs_q, rd, gcd_res << k_q);
                    state_d = StDone;
                end else if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + 6'd1;
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q > b_q) begin
                    a_d = (a_q - b_q) >> 1;
                end else begin
                    b_d = (b_q - a_q) >> 1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
            instr_q <= '0;
            sel_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            fail_q  <= 1'b0;
            code_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            regs_q  <= regs_d;
            instr_q <= instr_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            fail_q  <= fail_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        in_ready         = (state_q == StIdle);
        out_valid        = (state_q == StDone);
        instruction_fail = out_valid && fail_q;
        fail_code        = instruction_fail ? code_q : 3'd0;
        out_data         = '0;
        if (out_valid && !fail_q) begin
            for (int k = 0; k < int'(NUM_OUT); k++) begin
                out_data[DATA_W*k +: DATA_W] = rd_reg(regs_q, sel_q[5*k +: 5]);
            end
        end
    end

endmodule
